// File: rtl/pair_shift_pkg.sv
// Shared types and constants for the pair shift sequencer.
// Direction encoding matches the shift stage: 0 = left, 1 = right.
package pair_shift_pkg;

  localparam int SLICE_WIDTH = 8;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    OP_A = 3'd1,
    OP_B = 3'd2,
    OP_C = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/pair_shift_sequencer.sv
// Performs a 16-bit logical shift of a hi:lo pair using an external 8-bit
// combinational shifter, one slice shift per cycle, with a done pulse.
module pair_shift_sequencer
  import pair_shift_pkg::*;
#(
  parameter int SLICE_W = SLICE_WIDTH,
  parameter int AMT_W   = $clog2(2 * SLICE_W)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [2*SLICE_W-1:0]   valueIn,
  input  logic [AMT_W-1:0]       amountIn,
  input  logic                   dirIn,
  output logic                   busy,
  output logic                   done,
  output logic [2*SLICE_W-1:0]   valueOut,
  output logic [SLICE_W-1:0]     shOperand,
  output logic [SLICE_W-1:0]     shAmount,
  output logic                   shDirection,
  input  logic [SLICE_W-1:0]     shResult
);

  localparam logic [AMT_W-1:0] SLICE_AMT = AMT_W'(SLICE_W);

  state_t               state_reg, state_next;
  logic [SLICE_W-1:0]   hi_reg, lo_reg;
  logic [AMT_W-1:0]     amount_reg;
  logic                 dir_reg;
  logic [SLICE_W-1:0]   spill_reg, spill_next;
  logic [SLICE_W-1:0]   new_hi_reg, new_hi_next;
  logic [SLICE_W-1:0]   new_lo_reg, new_lo_next;
  logic [2*SLICE_W-1:0] value_reg;

  // Amounts of 8 and above need only one slice shift by n-8 (the low bits).
  logic                 wide_shift;
  logic [AMT_W-1:0]     low_amount;
  logic [AMT_W-1:0]     spill_amount;

  assign wide_shift   = amount_reg[AMT_W-1];
  assign low_amount   = {1'b0, amount_reg[AMT_W-2:0]};
  assign spill_amount = SLICE_AMT - amount_reg;

  always_comb begin
    state_next  = state_reg;
    spill_next  = spill_reg;
    new_hi_next = new_hi_reg;
    new_lo_next = new_lo_reg;
    shOperand   = '0;
    shAmount    = '0;
    shDirection = DIR_LEFT;

    case (state_reg)
      IDLE: begin
        if (start) begin
          if (amountIn == '0) begin
            state_next  = DONE;
            new_hi_next = valueIn[2*SLICE_W-1:SLICE_W];
            new_lo_next = valueIn[SLICE_W-1:0];
          end else begin
            state_next = OP_A;
          end
        end
      end
      OP_A: begin
        shOperand   = (dir_reg == DIR_RIGHT) ? hi_reg : lo_reg;
        shAmount    = SLICE_W'(low_amount);
        shDirection = dir_reg;
        if (wide_shift) begin
          state_next  = DONE;
          new_hi_next = (dir_reg == DIR_RIGHT) ? '0 : shResult;
          new_lo_next = (dir_reg == DIR_RIGHT) ? shResult : '0;
        end else begin
          state_next = OP_B;
          if (dir_reg == DIR_RIGHT) new_hi_next = shResult;
          else                      new_lo_next = shResult;
        end
      end
      OP_B: begin
        // Opposite-direction shift by 8-n recovers the bits crossing the slice boundary.
        shOperand   = (dir_reg == DIR_RIGHT) ? hi_reg : lo_reg;
        shAmount    = SLICE_W'(spill_amount);
        shDirection = ~dir_reg;
        spill_next  = shResult;
        state_next  = OP_C;
      end
      OP_C: begin
        shOperand   = (dir_reg == DIR_RIGHT) ? lo_reg : hi_reg;
        shAmount    = SLICE_W'(amount_reg);
        shDirection = dir_reg;
        if (dir_reg == DIR_RIGHT) new_lo_next = shResult | spill_reg;
        else                      new_hi_next = shResult | spill_reg;
        state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      hi_reg     <= '0;
      lo_reg     <= '0;
      amount_reg <= '0;
      dir_reg    <= DIR_LEFT;
      spill_reg  <= '0;
      new_hi_reg <= '0;
      new_lo_reg <= '0;
      value_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      spill_reg  <= spill_next;
      new_hi_reg <= new_hi_next;
      new_lo_reg <= new_lo_next;
      if (state_reg == IDLE && start) begin
        hi_reg     <= valueIn[2*SLICE_W-1:SLICE_W];
        lo_reg     <= valueIn[SLICE_W-1:0];
        amount_reg <= amountIn;
        dir_reg    <= dirIn;
      end
      if (state_next == DONE && state_reg != DONE) begin
        value_reg <= {new_hi_next, new_lo_next};
      end
    end
  end

  assign busy     = (state_reg != IDLE);
  assign done     = (state_reg == DONE);
  assign valueOut = value_reg;

endmodule
